lfsr_index_gen: RTL

//  Parametrised Galois LFSR with a request/response sampler that draws uniform

---
 rtl/lfsr_index_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/lfsr_index_gen.sv
// lfsr_index_gen: Galois LFSR with an unbiased, range-limited index sampler.
module lfsr_index_gen #(
  parameter int               NBITS     = 16,
  parameter logic [NBITS-1:0] TAPS      = 16'hB400,
  parameter logic [NBITS-1:0] INIT      = 16'hACE1,
  parameter int               IDXW      = 7,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [127:0]     data,
  input  logic [IDXW:0]    range,
  input  logic             req,
  output logic             ready,
  output logic             idx_valid,
  output logic [IDXW-1:0]  idx,
  output logic             err,
  output logic             fallback,
  output logic [NBITS-1:0] q
);
  localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
  typedef enum logic {IDLE, DRAW} state_t;
  state_t           state_q, state_d;
  logic [NBITS-1:0] q_q, q_d, fold, step;
  logic [IDXW:0]    range_q, range_d, r1, half_w;
  logic [TW-1:0]    tries_q, tries_d;
  logic [IDXW-1:0]  idx_q, idx_d, msk, cand, half;
  logic             vld_q, vld_d, err_q, err_d, fb_q, fb_d, ok, last;
  // Seed fold, LFSR step and the masked candidate with its rejection test.
  always_comb begin
    fold = '0;
    for (int k = 0; k < 128 / NBITS; k++) fold = fold ^ data[k*NBITS +: NBITS];
    step = q_q[0] ? (q_q >> 1) ^ TAPS : q_q >> 1;
    r1 = range_q - (IDXW+1)'(1);
    msk = r1[IDXW-1:0];
    for (int i = 0; i < IDXW; i++) msk = msk | (msk >> 1);
    cand = q_q[IDXW-1:0] & msk;
    half_w = {1'b0, msk} + (IDXW+1)'(1);
    half = half_w[IDXW:1];
    ok = {1'b0, cand} < range_q;
    last = tries_q == TW'(MAX_TRIES - 1);
  end
  // Next-state for the sampler FSM and LFSR; a seed load overrides the step.
  always_comb begin
    state_d = state_q;
    q_d = state_q == DRAW ? step : q_q;
    if (we) q_d = fold == '0 ? NBITS'(1) : fold;
    range_d = range_q;
    tries_d = tries_q;
    idx_d = idx_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    fb_d = 1'b0;
    if (state_q == IDLE) begin
      if (req) begin
        range_d = range;
        tries_d = '0;
        if (range == '0) begin
          vld_d = 1'b1;
          err_d = 1'b1;
          idx_d = '0;
        end else begin
          state_d = DRAW;
        end
      end
    end else if (ok || last) begin
      idx_d = ok ? cand : cand - half;
      fb_d = !ok;
      vld_d = 1'b1;
      state_d = IDLE;
    end else begin
      tries_d = tries_q + TW'(1);
    end
  end
  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q <= INIT;
      range_q <= '0;
      tries_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      fb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      range_q <= range_d;
      tries_q <= tries_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      err_q <= err_d;
      fb_q <= fb_d;
    end
  end
  assign ready = state_q == IDLE;
  assign idx_valid = vld_q;
  assign idx = idx_q;
  assign err = err_q;
  assign fallback = fb_q;
  assign q = q_q;
endmodule
